// File: rtl/prefetch_queue.sv
// rtl/prefetch_queue.sv - byte-wide instruction prefetch queue feeding decode
// Streams opcode bytes into a circular buffer and presents the oldest four as ope.
module prefetch_queue #(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  input  logic        consume,
  input  logic [2:0]  consume_len,
  output logic [31:0] ope,
  output logic [2:0]  ope_bytes,
  output logic [31:0] ope_eip,
  output logic        err
);

  localparam int            PW   = $clog2(DEPTH);
  localparam int            CW   = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   fetch_addr_q, fetch_addr_d;
  logic [31:0]   ope_eip_q, ope_eip_d;
  logic [31:0]   mem_addr_q, mem_addr_d;
  logic [31:0]   ope_q, ope_d;
  logic [2:0]    ope_bytes_q, ope_bytes_d;
  logic          mem_req_q, mem_req_d;
  logic          err_q, err_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];
  logic          ack;
  logic          consume_ok;
  logic [PW-1:0] lane_idx;

  assign ack        = mem_ack & mem_req_q;
  assign consume_ok = (consume_len != 3'd0) && (consume_len <= ope_bytes_q);

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fetch_addr_d = fetch_addr_q;
    ope_eip_d    = ope_eip_q;
    mem_addr_d   = mem_addr_q;
    mem_req_d    = mem_req_q;
    err_d        = err_q;
    buf_d        = buf_q;
    ope_d        = '0;
    lane_idx     = '0;

    if (flush) begin
      rd_ptr_d     = wr_ptr_q;
      count_d      = '0;
      fetch_addr_d = flush_addr;
      ope_eip_d    = flush_addr;
      // A request in flight must still be acked by memory, so park in DROP.
      if (state_q != IDLE) begin
        if (ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
    end else begin
      if (consume) begin
        if (consume_ok) begin
          rd_ptr_d  = rd_ptr_q + PW'(consume_len);
          count_d   = count_q - CW'(consume_len);
          ope_eip_d = ope_eip_q + {29'd0, consume_len};
        end else begin
          err_d = 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (count_q < FULL) begin
            state_d    = REQ;
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_addr_q;
          end
        end
        REQ: begin
          if (ack) begin
            buf_d[wr_ptr_q] = mem_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
            count_d         = count_d + CW'(1);
            fetch_addr_d    = fetch_addr_q + 32'd1;
            state_d         = IDLE;
            mem_req_d       = 1'b0;
          end
        end
        DROP: begin
          if (ack) begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
          end
        end
        default: begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
        end
      endcase
    end

    ope_bytes_d = (count_d >= CW'(4)) ? 3'd4 : 3'(count_d);
    for (int i = 0; i < 4; i++) begin
      lane_idx = rd_ptr_d + PW'(i);
      if (CW'(i) < count_d) begin
        ope_d[31-8*i -: 8] = buf_d[lane_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fetch_addr_q <= RESET_ADDR;
      ope_eip_q    <= RESET_ADDR;
      mem_addr_q   <= RESET_ADDR;
      mem_req_q    <= 1'b0;
      ope_q        <= '0;
      ope_bytes_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fetch_addr_q <= fetch_addr_d;
      ope_eip_q    <= ope_eip_d;
      mem_addr_q   <= mem_addr_d;
      mem_req_q    <= mem_req_d;
      ope_q        <= ope_d;
      ope_bytes_q  <= ope_bytes_d;
      err_q        <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ope       = ope_q;
  assign ope_bytes = ope_bytes_q;
  assign ope_eip   = ope_eip_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// tb/tb_prefetch_queue.sv - directed bench for prefetch_queue
// Memory returns addr[7:0] + 8'h10 after a programmable number of wait cycles.
module tb_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_data = 8'h00;
  logic        flush;
  logic [31:0] flush_addr;
  logic        consume;
  logic [2:0]  consume_len;
  logic [31:0] ope;
  logic [2:0]  ope_bytes;
  logic [31:0] ope_eip;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 0;
  int wait_cnt = 0;
  int ack_cnt  = 0;

  prefetch_queue #(.DEPTH(8), .RESET_ADDR(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .flush       (flush),
    .flush_addr  (flush_addr),
    .consume     (consume),
    .consume_len (consume_len),
    .ope         (ope),
    .ope_bytes   (ope_bytes),
    .ope_eip     (ope_eip),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req && mem_ack) ack_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      mem_ack = (wait_cnt >= mem_lat);
      wait_cnt++;
    end else begin
      mem_ack  = 1'b0;
      wait_cnt = 0;
    end
    mem_data = mem_addr[7:0] + 8'h10;
  end

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; flush_addr = '0; consume = 1'b0; consume_len = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    n_checks++; if (ope !== 32'h0) begin n_fail++; $display("FAIL rst_ope: got %h want 0", ope); end
    n_checks++; if (ope_bytes !== 3'd0) begin n_fail++; $display("FAIL rst_ope_bytes: got %0d want 0", ope_bytes); end
    n_checks++; if (ope_eip !== 32'h0) begin n_fail++; $display("FAIL rst_ope_eip: got %h want 0", ope_eip); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
  endtask

  task automatic test_fill();
    int base;
    int seen;
    base = ack_cnt;
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL fill_first_req: req=%b addr=%h want 1/0", mem_req, mem_addr); end
    repeat (20) @(negedge clk);
    n_checks++; if (ope !== 32'h10111213) begin n_fail++; $display("FAIL fill_ope: got %h want 10111213", ope); end
    n_checks++; if (ope_bytes !== 3'd4) begin n_fail++; $display("FAIL fill_ope_bytes: got %0d want 4", ope_bytes); end
    n_checks++; if (ope_eip !== 32'h0) begin n_fail++; $display("FAIL fill_ope_eip: got %h want 0", ope_eip); end
    n_checks++; if (ack_cnt - base !== 8) begin n_fail++; $display("FAIL fill_acks: got %0d want 8", ack_cnt - base); end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req) seen = 1;
      @(negedge clk);
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL full_no_req: got req while full"); end
  endtask

  task automatic test_consume();
    consume = 1'b1; consume_len = 3'd2;
    @(negedge clk);
    consume = 1'b0;
    n_checks++; if (ope !== 32'h12131415) begin n_fail++; $display("FAIL cons_ope: got %h want 12131415", ope); end
    n_checks++; if (ope_eip !== 32'h2) begin n_fail++; $display("FAIL cons_eip: got %h want 2", ope_eip); end
    n_checks++; if (ope_bytes !== 3'd4) begin n_fail++; $display("FAIL cons_bytes: got %0d want 4", ope_bytes); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin n_fail++; $display("FAIL cons_refill_req: req=%b addr=%h want 1/8", mem_req, mem_addr); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_flush();
    int k;
    mem_lat = 2; consume = 1'b1; consume_len = 3'd4;
    @(negedge clk);
    consume = 1'b0;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL flush_wait_req: req=%b want 1", mem_req); end
    flush = 1'b1; flush_addr = 32'h100;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (ope_bytes !== 3'd0) begin n_fail++; $display("FAIL flush_bytes: got %0d want 0", ope_bytes); end
    n_checks++; if (ope_eip !== 32'h100) begin n_fail++; $display("FAIL flush_eip: got %h want 100", ope_eip); end
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0A) begin n_fail++; $display("FAIL flush_stale_hold: req=%b addr=%h want 1/0a", mem_req, mem_addr); end
    k = 0;
    while (!(mem_req === 1'b1 && mem_addr === 32'h100) && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (mem_addr !== 32'h100) begin n_fail++; $display("FAIL flush_new_req: addr=%h want 100", mem_addr); end
    k = 0;
    while (ope_bytes === 3'd0 && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (ope[31:24] !== 8'h10) begin n_fail++; $display("FAIL flush_first_byte: got %h want 10", ope[31:24]); end
    n_checks++; if (ope_eip !== 32'h100) begin n_fail++; $display("FAIL flush_first_eip: got %h want 100", ope_eip); end
  endtask

  task automatic test_err();
    mem_lat = 0;
    repeat (20) @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_pre: got %b want 0", err); end
    flush = 1'b1; flush_addr = 32'h200;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (ope_bytes !== 3'd2 || ope !== 32'h10110000) begin n_fail++; $display("FAIL err_two_bytes: bytes=%0d ope=%h want 2/10110000", ope_bytes, ope); end
    consume = 1'b1; consume_len = 3'd3;
    @(negedge clk);
    consume = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b want 1", err); end
    n_checks++; if (ope_eip !== 32'h200 || ope_bytes !== 3'd2) begin n_fail++; $display("FAIL err_no_move: eip=%h bytes=%0d want 200/2", ope_eip, ope_bytes); end
    repeat (10) @(negedge clk);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; flush_addr = 32'hFFFF_FFFE;
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(negedge clk);
    n_checks++; if (ope !== 32'h0E0F1011 || ope_bytes !== 3'd4) begin n_fail++; $display("FAIL wrap_ope: ope=%h bytes=%0d want 0e0f1011/4", ope, ope_bytes); end
    n_checks++; if (ope_eip !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_eip0: got %h want fffffffe", ope_eip); end
    consume = 1'b1; consume_len = 3'd2;
    @(negedge clk);
    consume = 1'b0;
    n_checks++; if (ope_eip !== 32'h0) begin n_fail++; $display("FAIL wrap_eip1: got %h want 0", ope_eip); end
    n_checks++; if (ope[31:16] !== 16'h1011 || ope_bytes !== 3'd2) begin n_fail++; $display("FAIL wrap_ope1: ope=%h bytes=%0d want 1011..../2", ope, ope_bytes); end
  endtask

  task automatic test_same_edge();
    int k;
    k = 0;
    while (!(mem_req === 1'b1 && ope_bytes !== 3'd0) && k < 20) begin @(negedge clk); k++; end
    n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL same_wait_req: req=%b want 1", mem_req); end
    flush = 1'b1; flush_addr = 32'h300; consume = 1'b1; consume_len = 3'd1;
    @(negedge clk);
    flush = 1'b0; consume = 1'b0;
    n_checks++; if (ope_bytes !== 3'd0 || ope !== 32'h0) begin n_fail++; $display("FAIL same_empty: bytes=%0d ope=%h want 0/0", ope_bytes, ope); end
    n_checks++; if (ope_eip !== 32'h300) begin n_fail++; $display("FAIL same_eip: got %h want 300", ope_eip); end
    n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL same_idle: req=%b want 0", mem_req); end
    repeat (2) @(negedge clk);
    n_checks++; if (ope !== 32'h10000000 || ope_bytes !== 3'd1) begin n_fail++; $display("FAIL same_first: ope=%h bytes=%0d want 10000000/1", ope, ope_bytes); end
  endtask

  task automatic test_reset_mid();
    int k;
    k = 0;
    while (mem_req !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_rst_mem: req=%b addr=%h want 0/0", mem_req, mem_addr); end
    n_checks++; if (ope !== 32'h0 || ope_bytes !== 3'd0) begin n_fail++; $display("FAIL mid_rst_ope: ope=%h bytes=%0d want 0/0", ope, ope_bytes); end
    n_checks++; if (ope_eip !== 32'h0 || err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_eip_err: eip=%h err=%b want 0/0", ope_eip, err); end
    reset = 1'b1; consume = 1'b1; consume_len = 3'd0;
    @(negedge clk);
    consume = 1'b0;
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL len0_err: got %b want 1", err); end
    n_checks++; if (ope_eip !== 32'h0) begin n_fail++; $display("FAIL len0_eip: got %h want 0", ope_eip); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_consume();
    test_flush();
    test_err();
    test_wrap();
    test_same_edge();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Byte-wide instruction prefetch queue that sits directly upstream of `decode` and replaces the word-at-a-time fetch path. It streams opcode bytes from byte-addressed instruction memory into a small circular buffer and presents the oldest four bytes to decode as a 32-bit `ope` window. Decode consumes each variable-length instruction by byte count. A flush input redirects the fetch stream when EIP is loaded, for example on a jump or call.

## Interface
- `DEPTH`, default 8: queue capacity in bytes; power of two, at least 4.
- `RESET_ADDR`, default 32'h0000_0000: fetch address after reset.
- `clk`, in, 1: system clock; all state updates on the rising edge.
- `reset`, in, 1: synchronous, active-low reset (low = reset).
- `mem_req`, out, 1: read request to instruction memory.
- `mem_addr`, out, 32: byte address of the request.
- `mem_ack`, in, 1: `mem_data` valid; sampled only while `mem_req` = 1.
- `mem_data`, in, 8: returned byte.
- `flush`, in, 1: discard the queue and restart fetch at `flush_addr`.
- `flush_addr`, in, 32: new fetch and EIP address.
- `consume`, in, 1: decode retires `consume_len` bytes this cycle.
- `consume_len`, in, 3: byte count, legal range 1..4.
- `ope`, out, 32: oldest byte in [31:24], next bytes in [23:16], [15:8], [7:0]. Invalid byte lanes are driven 0.
- `ope_bytes`, out, 3: number of valid bytes in `ope`, equal to min(count, 4).
- `ope_eip`, out, 32: address of the byte in `ope[31:24]`.
- `err`, out, 1: sticky illegal-consume flag.

## Operation
- State: read pointer and write pointer (log2 DEPTH bits each, wrap modulo DEPTH), `count` (0..DEPTH), `fetch_addr`, `ope_eip`, and the memory FSM.
- Memory FSM has three states:
  - IDLE: when `count` < DEPTH, go to REQ and drive `mem_req`=1, `mem_addr`=`fetch_addr`.
  - REQ: `mem_req` and `mem_addr` are held stable until `mem_ack`. On ack, write the byte, increment `fetch_addr`, and return to IDLE.
  - DROP: hold the stale request until `mem_ack`, discard the byte, then return to IDLE.
- One request is outstanding at most. Fetch may run back to back: IDLE→REQ happens in the cycle after an ack.
- Full condition: no request is issued while `count` = DEPTH. The REQ slot is reserved at issue, so an ack can never overflow the queue.
- Consume: when `consume`=1 and 1 ≤ `consume_len` ≤ `ope_bytes`:
  - the read pointer and `ope_eip` each advance by `consume_len`;
  - `count` decreases by `consume_len`.
- Illegal consume: when `consume_len` = 0 or `consume_len` > `ope_bytes`, the request is ignored and `err` is set. `err` clears only on reset.
- Simultaneous ack and consume: both are applied, so `count` becomes `count` − `consume_len` + 1.
- Flush has priority over consume and ack. On the flush edge:
  - the pointers are equalised and `count` = 0;
  - `fetch_addr` = `ope_eip` = `flush_addr`.
  - If the FSM is in REQ without `mem_ack`, go to DROP.
  - If `mem_ack` arrives on the flush edge, that byte is discarded and the FSM goes to IDLE.
  - Flush while already in DROP: stay in DROP and take the new `flush_addr`.
- Arithmetic:
  - `fetch_addr` and `ope_eip` are 32-bit and wrap from 32'hFFFF_FFFF to 0.
  - `count` never goes below 0 or above DEPTH.

## Timing
- Reset values (first edge with `reset`=0):
  - `mem_req`=0, `mem_addr`=RESET_ADDR;
  - `ope`=0, `ope_bytes`=0;
  - `ope_eip`=RESET_ADDR, `err`=0;
  - FSM=IDLE, `count`=0.
- Reset asserted mid-request abandons the request immediately; memory must tolerate `mem_req` dropping.
- `mem_req` first rises in the cycle after the first edge where `reset`=1.
- `mem_ack` may be asserted in the same cycle `mem_req` rises (zero-wait memory).
- All outputs are registered. A byte acked at edge N appears in `ope`/`ope_bytes` after edge N.
- With zero-wait memory the throughput is one byte every 2 cycles (REQ, IDLE, REQ, …).
- Flush at edge N: `ope_bytes`=0 after N. The new request is issued in the cycle after N, or after the DROP ack if a stale request was pending.
- Consume at edge N: the updated `ope`, `ope_bytes` and `ope_eip` are visible after N.

## Test plan
The memory model returns `mem_data` = `mem_addr[7:0]` + 8'h10.
- Reset release, zero-wait memory -> after 8 acks: `ope`=32'h10111213, `ope_bytes`=4, `ope_eip`=0, `count`=8, `mem_req` stays 0.
- From full, `consume`=1, `consume_len`=2 -> `ope`=32'h12131415, `ope_eip`=2, then `mem_req`=1 at `mem_addr`=8.
- 3-cycle memory; `flush` with `flush_addr`=32'h100 while REQ is pending:
  - `ope_bytes`=0 immediately;
  - the stale byte is dropped;
  - the next request is at 32'h100;
  - the first `ope`[31:24]=8'h10 with `ope_eip`=32'h100.
- `ope_bytes`=2, `consume_len`=3 -> no pointer change, `err`=1 and it stays 1 until reset; `consume_len`=0 also sets `err`.
- `flush_addr`=32'hFFFF_FFFE, fill 4 bytes:
  - `ope`=32'h0E0F1011;
  - after consuming 2, `ope_eip`=0 and `ope`[31:16]=16'h1011.
- Same-edge `flush`, `consume` and `mem_ack` -> flush wins: `count`=0, acked byte discarded, `ope_eip`=`flush_addr`. Then `reset`=0 mid-REQ -> all outputs at reset values after that edge.
